// File: rtl/seq_age_tracker.sv
// In-flight sequence-number manager: allocation, in-order multi-lane commit,
// squash/flush rewind, sticky protocol error and wraparound-correct age queries.
module seq_age_tracker #(
  parameter int p_seq_num_bits = 5,
  parameter int p_num_commit   = 2,
  parameter int p_num_query    = 2
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         alloc_val,
  output logic                                         alloc_rdy,
  output logic [p_seq_num_bits-1:0]                    alloc_seq_num,
  input  logic [p_num_commit-1:0]                      commit_val,
  input  logic [p_num_commit-1:0][p_seq_num_bits-1:0]  commit_seq_num,
  input  logic                                         squash_val,
  input  logic [p_seq_num_bits-1:0]                    squash_seq_num,
  input  logic                                         flush_val,
  input  logic [p_num_query-1:0][p_seq_num_bits-1:0]   query_seq_num_0,
  input  logic [p_num_query-1:0][p_seq_num_bits-1:0]   query_seq_num_1,
  output logic [p_num_query-1:0]                       query_older,
  output logic [p_seq_num_bits-1:0]                    oldest_seq_num,
  output logic [p_seq_num_bits:0]                      in_flight,
  output logic                                         empty,
  output logic                                         full,
  output logic                                         err
);

  localparam int w  = p_seq_num_bits;
  localparam int pw = p_seq_num_bits + 1;
  localparam logic [pw-1:0] cap = {1'b1, {w{1'b0}}};

  // Pointers carry one extra wrap bit so that full and empty are distinguishable.
  logic [pw-1:0] head, tail, head_next, tail_next;
  logic          err_next;

  logic [pw-1:0] commit_cnt, commit_apply_cnt;
  logic          contig_bad, lane_bad, over_bad, beyond_bad, commit_bad;
  logic [w-1:0]  squash_off;
  logic          squash_act, squash_legal, squash_apply, squash_bad;
  logic          alloc_fire;

  assign in_flight      = tail - head;
  assign empty          = (in_flight == '0);
  assign full           = (in_flight == cap);
  assign alloc_rdy      = !full && !squash_val && !flush_val;
  assign alloc_seq_num  = tail[w-1:0];
  assign oldest_seq_num = head[w-1:0];
  assign alloc_fire     = alloc_val && alloc_rdy;

  assign squash_off   = squash_seq_num - head[w-1:0];
  assign squash_act   = squash_val && !flush_val;
  assign squash_legal = ({1'b0, squash_off} < in_flight);
  assign squash_apply = squash_act && squash_legal;
  assign squash_bad   = squash_act && !squash_legal;

  always_comb begin
    commit_cnt = '0;
    contig_bad = 1'b0;
    lane_bad   = 1'b0;
    beyond_bad = 1'b0;
    for (int k = 0; k < p_num_commit; k++) begin
      if (commit_val[k]) begin
        commit_cnt = commit_cnt + pw'(1);
        if (commit_seq_num[k] != head[w-1:0] + w'(k)) lane_bad = 1'b1;
        // A lane past the surviving squash boundary would retire a discarded number.
        if (squash_apply && (pw'(k) > {1'b0, squash_off})) beyond_bad = 1'b1;
      end
      if (k > 0 && commit_val[k] && !commit_val[k-1]) contig_bad = 1'b1;
    end
    over_bad         = (commit_cnt > in_flight);
    commit_bad       = contig_bad || lane_bad || over_bad || beyond_bad;
    commit_apply_cnt = commit_bad ? '0 : commit_cnt;
  end

  always_comb begin
    head_next = head + commit_apply_cnt;
    tail_next = tail;
    if (flush_val)         tail_next = head + commit_apply_cnt;
    else if (squash_apply) tail_next = head + {1'b0, squash_off} + pw'(1);
    else if (alloc_fire)   tail_next = tail + pw'(1);
    err_next = err || commit_bad || squash_bad;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      err  <= 1'b0;
    end else begin
      head <= head_next;
      tail <= tail_next;
      err  <= err_next;
    end
  end

  // Both operands are rebased to the oldest number before an unsigned compare.
  always_comb begin
    query_older = '0;
    for (int i = 0; i < p_num_query; i++) begin
      query_older[i] = (query_seq_num_0[i] < query_seq_num_1[i])
                     ^ (query_seq_num_0[i] < head[w-1:0])
                     ^ (query_seq_num_1[i] < head[w-1:0]);
    end
  end

endmodule

// File: tb/tb_seq_age_tracker.sv
// Bench for seq_age_tracker: hand sequences for fill/wrap/query/flush/reset,
// plus a vector table whose expected post-states flow through a scoreboard queue.
module tb_seq_age_tracker;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            alloc_val;
  logic            alloc_rdy;
  logic [4:0]      alloc_seq_num;
  logic [1:0]      commit_val;
  logic [1:0][4:0] commit_seq_num;
  logic            squash_val;
  logic [4:0]      squash_seq_num;
  logic            flush_val;
  logic [1:0][4:0] query_seq_num_0;
  logic [1:0][4:0] query_seq_num_1;
  logic [1:0]      query_older;
  logic [4:0]      oldest_seq_num;
  logic [5:0]      in_flight;
  logic            empty;
  logic            full;
  logic            err;

  int checks = 0;
  int errors = 0;

  seq_age_tracker #(.p_seq_num_bits(5), .p_num_commit(2), .p_num_query(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_val(alloc_val), .alloc_rdy(alloc_rdy), .alloc_seq_num(alloc_seq_num),
    .commit_val(commit_val), .commit_seq_num(commit_seq_num),
    .squash_val(squash_val), .squash_seq_num(squash_seq_num), .flush_val(flush_val),
    .query_seq_num_0(query_seq_num_0), .query_seq_num_1(query_seq_num_1),
    .query_older(query_older), .oldest_seq_num(oldest_seq_num),
    .in_flight(in_flight), .empty(empty), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       alloc;
    logic [1:0] cval;
    logic [4:0] c0;
    logic [4:0] c1;
    logic       sq;
    logic [4:0] sqn;
    logic       fl;
    logic       e_rdy;
    logic [5:0] e_inf;
    logic [4:0] e_old;
    logic [4:0] e_alloc;
    logic       e_err;
  } vec_t;

  vec_t tbl[26];
  vec_t sb[$];

  function automatic vec_t mk(input int a, input int cv, input int c0, input int c1,
                              input int sq, input int sqn, input int fl,
                              input int rdy, input int inf, input int old,
                              input int al, input int er);
    vec_t v;
    v.alloc = 1'(a);   v.cval = 2'(cv);  v.c0 = 5'(c0);    v.c1 = 5'(c1);
    v.sq = 1'(sq);     v.sqn = 5'(sqn);  v.fl = 1'(fl);
    v.e_rdy = 1'(rdy); v.e_inf = 6'(inf); v.e_old = 5'(old);
    v.e_alloc = 5'(al); v.e_err = 1'(er);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input int a, input int cv, input int c0, input int c1,
                       input int sq, input int sqn, input int fl);
    alloc_val         = 1'(a);
    commit_val        = 2'(cv);
    commit_seq_num[0] = 5'(c0);
    commit_seq_num[1] = 5'(c1);
    squash_val        = 1'(sq);
    squash_seq_num    = 5'(sqn);
    flush_val         = 1'(fl);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk_state(input string nm, input int inf, input int old,
                           input int al, input int er);
    chk({nm, ".in_flight"}, 32'(in_flight), inf);
    chk({nm, ".oldest"}, 32'(oldest_seq_num), old);
    chk({nm, ".alloc_seq"}, 32'(alloc_seq_num), al);
    chk({nm, ".err"}, 32'(err), er);
    chk({nm, ".empty"}, 32'(empty), (inf == 0) ? 1 : 0);
    chk({nm, ".full"}, 32'(full), (inf == 32) ? 1 : 0);
  endtask

  task automatic set_query(input int a0, input int b0, input int a1, input int b1);
    query_seq_num_0[0] = 5'(a0);
    query_seq_num_1[0] = 5'(b0);
    query_seq_num_0[1] = 5'(a1);
    query_seq_num_1[1] = 5'(b1);
  endtask

  // Scoreboard consumer: each pushed record is the state expected after one edge.
  always begin
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      vec_t e;
      e = sb.pop_front();
      chk_state("vec", int'(e.e_inf), int'(e.e_old), int'(e.e_alloc), int'(e.e_err));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0,  1, 1, 31, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 0, 0, 0,  1, 2, 31, 1, 0);
    tbl[2]  = mk(1, 0, 0, 0, 0, 0, 0,  1, 3, 31, 2, 0);
    tbl[3]  = mk(1, 0, 0, 0, 0, 0, 0,  1, 4, 31, 3, 0);
    tbl[4]  = mk(1, 0, 0, 0, 0, 0, 0,  1, 5, 31, 4, 0);
    tbl[5]  = mk(1, 0, 0, 0, 0, 0, 0,  1, 6, 31, 5, 0);
    tbl[6]  = mk(1, 3, 31, 0, 0, 0, 0, 1, 5, 1, 6, 0);
    tbl[7]  = mk(0, 3, 1, 2, 0, 0, 0,  1, 3, 3, 6, 0);
    tbl[8]  = mk(1, 1, 3, 0, 0, 0, 0,  1, 3, 4, 7, 0);
    tbl[9]  = mk(1, 0, 0, 0, 0, 0, 0,  1, 4, 4, 8, 0);
    tbl[10] = mk(1, 0, 0, 0, 0, 0, 0,  1, 5, 4, 9, 0);
    tbl[11] = mk(1, 0, 0, 0, 0, 0, 0,  1, 6, 4, 10, 0);
    tbl[12] = mk(1, 1, 4, 0, 1, 6, 0,  0, 2, 5, 7, 0);
    tbl[13] = mk(1, 0, 0, 0, 0, 0, 0,  1, 3, 5, 8, 0);
    tbl[14] = mk(0, 1, 6, 0, 0, 0, 0,  1, 3, 5, 8, 1);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0,  1, 3, 5, 8, 1);
    tbl[16] = mk(0, 1, 5, 0, 1, 20, 0, 0, 2, 6, 8, 1);
    tbl[17] = mk(0, 2, 0, 7, 0, 0, 0,  1, 2, 6, 8, 1);
    tbl[18] = mk(0, 3, 6, 7, 0, 0, 0,  1, 0, 8, 8, 1);
    tbl[19] = mk(0, 3, 8, 9, 0, 0, 0,  1, 0, 8, 8, 1);
    tbl[20] = mk(1, 0, 0, 0, 0, 0, 0,  1, 1, 8, 9, 1);
    tbl[21] = mk(1, 0, 0, 0, 0, 0, 0,  1, 2, 8, 10, 1);
    tbl[22] = mk(1, 0, 0, 0, 0, 0, 0,  1, 3, 8, 11, 1);
    tbl[23] = mk(0, 0, 0, 0, 1, 10, 0, 0, 3, 8, 11, 1);
    tbl[24] = mk(0, 3, 8, 9, 1, 8, 0,  0, 1, 8, 9, 1);
    tbl[25] = mk(1, 1, 8, 0, 1, 20, 1, 0, 0, 9, 9, 1);

    rst_n = 1'b0;
    idle();
    set_query(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_state("reset", 0, 0, 0, 0);
    chk("reset.alloc_rdy", 32'(alloc_rdy), 1);

    // Fill all 32 numbers, then hold alloc_val against a full tracker.
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i > 0) @(negedge clk);
      drive(1, 0, 0, 0, 0, 0, 0);
      #1;
      chk($sformatf("fill%0d.alloc_seq", i), 32'(alloc_seq_num), i);
      chk($sformatf("fill%0d.rdy", i), 32'(alloc_rdy), 1);
    end
    @(posedge clk);
    #1;
    chk_state("full", 32, 0, 0, 0);
    chk("full.alloc_rdy", 32'(alloc_rdy), 0);
    @(posedge clk);
    #1;
    chk("full_hold.in_flight", 32'(in_flight), 32);

    @(negedge clk);
    drive(0, 3, 0, 1, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_state("commit2", 30, 2, 0, 0);
    chk("commit2.alloc_rdy", 32'(alloc_rdy), 1);

    // Retire up to head=28 while allocating 0..3 past the wrap.
    for (int j = 0; j < 13; j++) begin
      @(negedge clk);
      drive((j < 4) ? 1 : 0, 3, 2 + 2 * j, 3 + 2 * j, 0, 0, 0);
    end
    @(negedge clk);
    idle();
    #1;
    chk_state("head28", 8, 28, 4, 0);

    set_query(30, 1, 1, 30);
    #1;
    chk("q(30,1)", 32'(query_older[0]), 1);
    chk("q(1,30)", 32'(query_older[1]), 0);
    set_query(2, 2, 28, 3);
    #1;
    chk("q(2,2)", 32'(query_older[0]), 0);
    chk("q(28,3)", 32'(query_older[1]), 1);
    set_query(29, 28, 31, 0);
    #1;
    chk("q(29,28)", 32'(query_older[0]), 0);
    chk("q(31,0)", 32'(query_older[1]), 1);
    set_query(0, 0, 0, 0);

    @(negedge clk);
    drive(0, 3, 28, 29, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_state("six_inflight", 6, 30, 4, 0);
    @(negedge clk);
    drive(1, 1, 30, 0, 0, 0, 1);
    #1;
    chk("flush.alloc_rdy", 32'(alloc_rdy), 0);
    @(posedge clk);
    #1;
    chk_state("flush", 0, 31, 31, 0);

    foreach (tbl[r]) begin
      @(negedge clk);
      drive(int'(tbl[r].alloc), int'(tbl[r].cval), int'(tbl[r].c0), int'(tbl[r].c1),
            int'(tbl[r].sq), int'(tbl[r].sqn), int'(tbl[r].fl));
      #1;
      chk($sformatf("vec%0d.alloc_rdy", r), 32'(alloc_rdy), 32'(tbl[r].e_rdy));
      sb.push_back(tbl[r]);
    end
    @(negedge clk);
    idle();
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(sb.size()), 0);

    // Reset mid-operation beats live inputs; then squash out of range sets err.
    @(negedge clk);
    rst_n = 1'b0;
    drive(1, 1, 9, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_state("mid_reset", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 5, 0);
    #1;
    chk("bad_squash.alloc_rdy", 32'(alloc_rdy), 0);
    @(posedge clk);
    #1;
    chk_state("bad_squash", 2, 0, 2, 1);
    @(negedge clk);
    idle();
    @(posedge clk);
    #1;
    chk("err_sticky", 32'(err), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
